// File: rtl/button_capture_if.sv
// rtl/button_capture_if.sv - button pins, CPU poll strobe and status outputs of button_capture
//
// Purpose:
//   Groups the player-button pins, the CPU poll strobe and the capture block's
//   outputs so the board/CPU side and the capture block share one bundle.
// Signals:
//   red_button, blue_button,
//   green_button, yellow_button  raw asynchronous button pins
//   poll                         high while the CPU reads data-memory address 7
//   button_out[31:0]             status word {28'b0, overrun, color[1:0], valid}
//   held[3:0]                    debounced levels {yellow, green, blue, red}
// Modports:
//   master  board/CPU side: drives pins and poll, observes status
//   slave   capture block: samples pins and poll, drives status

interface button_capture_if;
  logic        red_button;
  logic        blue_button;
  logic        green_button;
  logic        yellow_button;
  logic        poll;
  logic [31:0] button_out;
  logic [3:0]  held;

  modport master (
    output red_button,
    output blue_button,
    output green_button,
    output yellow_button,
    output poll,
    input  button_out,
    input  held
  );

  modport slave (
    input  red_button,
    input  blue_button,
    input  green_button,
    input  yellow_button,
    input  poll,
    output button_out,
    output held
  );
endinterface

// File: rtl/button_capture.sv
// rtl/button_capture.sv - debounced player-button capture with read-to-clear status word
//
// Purpose:
//   Synchronises and debounces the four player buttons, remembers the first
//   new press and reports it to the CPU as a 32-bit status word. The press is
//   cleared on the cycle the CPU's poll strobe falls.
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synced samples needed to accept a level change (>= 1)
//   ACTIVE_LOW       1 = raw pins are active-low and are inverted before synchronising
// Ports:
//   clock            system clock
//   reset            asynchronous active-high reset
//   bus (slave)      pins and poll in; button_out and held out
// Status word:
//   [0] valid, [2:1] color (00 red, 01 blue, 10 green, 11 yellow), [3] overrun, [31:4] zero

module button_capture #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input logic             clock,
  input logic             reset,
  button_capture_if.slave bus
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);
  // The counter value on the edge before acceptance; the accepting edge is
  // the DEBOUNCE_CYCLES-th consecutive stable sample.
  localparam logic [CW-1:0] LP_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning: polarity fix then 2-flop synchroniser per button.
  // Bit order everywhere is {yellow, green, blue, red} = index {3,2,1,0},
  // so the bit index is also the color code.
  // ---------------------------------------------------------------------
  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  assign w_raw = {bus.yellow_button, bus.green_button,
                  bus.blue_button,   bus.red_button} ^ {4{ACTIVE_LOW}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-button debounce FSMs. r_press is a one-cycle pulse on the edge a
  // press is accepted; r_held mirrors the debounced level.
  // ---------------------------------------------------------------------
  state_t        r_state [4];
  logic [CW-1:0] r_cnt   [4];
  logic [3:0]    r_held;
  logic [3:0]    r_press;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
      r_held  <= '0;
      r_press <= '0;
    end else begin
      r_press <= '0;
      for (int i = 0; i < 4; i++) begin
        case (r_state[i])
          ST_IDLE: begin
            if (r_sync2[i]) begin
              if (DEBOUNCE_CYCLES <= 1) begin
                // A single stable sample is already enough.
                r_state[i] <= ST_PRESSED;
                r_cnt[i]   <= '0;
                r_held[i]  <= 1'b1;
                r_press[i] <= 1'b1;
              end else begin
                r_state[i] <= ST_PRESS_WAIT;
                r_cnt[i]   <= LP_ONE;
              end
            end
          end

          ST_PRESS_WAIT: begin
            if (!r_sync2[i]) begin
              r_state[i] <= ST_IDLE;
              r_cnt[i]   <= '0;
            end else if (r_cnt[i] == LP_LAST) begin
              r_state[i] <= ST_PRESSED;
              r_cnt[i]   <= '0;
              r_held[i]  <= 1'b1;
              r_press[i] <= 1'b1;
            end else begin
              r_cnt[i] <= r_cnt[i] + LP_ONE;
            end
          end

          ST_PRESSED: begin
            if (!r_sync2[i]) begin
              if (DEBOUNCE_CYCLES <= 1) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
                r_held[i]  <= 1'b0;
              end else begin
                r_state[i] <= ST_RELEASE_WAIT;
                r_cnt[i]   <= LP_ONE;
              end
            end
          end

          ST_RELEASE_WAIT: begin
            if (r_sync2[i]) begin
              // Bounce back high: still pressed, no new pulse.
              r_state[i] <= ST_PRESSED;
              r_cnt[i]   <= '0;
            end else if (r_cnt[i] == LP_LAST) begin
              r_state[i] <= ST_IDLE;
              r_cnt[i]   <= '0;
              r_held[i]  <= 1'b0;
            end else begin
              r_cnt[i] <= r_cnt[i] + LP_ONE;
            end
          end

          default: begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Capture register and read-to-clear.
  // ---------------------------------------------------------------------
  logic       r_poll_d;
  logic       r_valid;
  logic [1:0] r_color;
  logic       r_overrun;
  logic       w_clear;
  logic       w_any_press;
  logic [1:0] w_press_color;

  // Clear happens on the cycle the CPU's read strobe drops.
  assign w_clear     = r_poll_d & ~bus.poll;
  assign w_any_press = |r_press;

  // Lowest index wins: red > blue > green > yellow.
  always_comb begin
    w_press_color = 2'd3;
    if (r_press[0]) begin
      w_press_color = 2'd0;
    end else if (r_press[1]) begin
      w_press_color = 2'd1;
    end else if (r_press[2]) begin
      w_press_color = 2'd2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_poll_d  <= 1'b0;
      r_valid   <= 1'b0;
      r_color   <= 2'd0;
      r_overrun <= 1'b0;
    end else begin
      r_poll_d <= bus.poll;
      if (w_any_press) begin
        // A press coinciding with the clear edge starts a fresh capture
        // rather than being lost or counted as an overrun.
        if (!r_valid || w_clear) begin
          r_valid   <= 1'b1;
          r_color   <= w_press_color;
          r_overrun <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_clear) begin
        r_valid   <= 1'b0;
        r_color   <= 2'd0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.button_out = {28'd0, r_overrun, r_color, r_valid};
  assign bus.held       = r_held;

endmodule

// File: tb/tb_button_capture.sv
// tb/tb_button_capture.sv - self-checking bench for button_capture

module tb_button_capture;

  localparam int DB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  button_capture_if bus ();

  button_capture #(
    .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each debounced level follows its synced input once the
  // synced input has disagreed with it for DB consecutive samples. Synced
  // input is the raw pin two edges late. An accepted press is captured on
  // the following edge.
  bit       m_s1   [4];
  bit       m_s2   [4];
  int       m_run  [4];
  bit       m_held [4];
  bit       m_pulse[4];
  bit       m_poll_d;
  bit       m_valid;
  bit [1:0] m_color;
  bit       m_ovr;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_run[i] = 0; m_held[i] = 0; m_pulse[i] = 0;
      end
      m_poll_d = 0; m_valid = 0; m_color = 0; m_ovr = 0;
    end else begin
      bit [3:0] raw;
      bit       clr;
      int       first;
      raw   = {bus.yellow_button, bus.green_button, bus.blue_button, bus.red_button};
      clr   = m_poll_d && !bus.poll;
      first = -1;
      for (int i = 3; i >= 0; i--) if (m_pulse[i]) first = i;
      if (first >= 0) begin
        if (!m_valid || clr) begin
          m_valid = 1; m_color = 2'(first); m_ovr = 0;
        end else begin
          m_ovr = 1;
        end
      end else if (clr) begin
        m_valid = 0; m_color = 0; m_ovr = 0;
      end
      m_poll_d = bus.poll;
      for (int i = 0; i < 4; i++) begin
        bit sv;
        sv      = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
        m_pulse[i] = 0;
        if (sv != m_held[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == DB) begin
          m_held[i]  = sv;
          m_run[i]   = 0;
          m_pulse[i] = sv;
        end
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (!reset) begin
      check("model_out", bus.button_out, {28'd0, m_ovr, m_color, m_valid});
      check("model_held", {28'd0, bus.held},
            {28'd0, m_held[3], m_held[2], m_held[1], m_held[0]});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    bus.red_button    = 1'b0;
    bus.blue_button   = 1'b0;
    bus.green_button  = 1'b0;
    bus.yellow_button = 1'b0;
    bus.poll          = 1'b0;
    tick(2);
    check("reset_out", bus.button_out, 32'h0);
    check("reset_held", {28'd0, bus.held}, 32'h0);
    reset = 1'b0;
    tick(1);

    // 1: blue press latency
    bus.blue_button = 1'b1;
    tick(6);
    check("t1_before_7", bus.button_out, 32'h0);
    tick(1);
    check("t1_at_7", bus.button_out, 32'h3);
    check("t1_held", {28'd0, bus.held}, 32'h2);
    bus.blue_button = 1'b0;
    tick(10);
    check("t1_release_held", {28'd0, bus.held}, 32'h0);
    check("t1_still_valid", bus.button_out, 32'h3);
    bus.poll = 1'b1;
    tick(1);
    bus.poll = 1'b0;
    tick(1);
    check("t1_cleared", bus.button_out, 32'h0);

    // 2: glitchy green never accepted
    for (int k = 0; k < 10; k++) begin
      bus.green_button = ~bus.green_button;
      tick(2);
    end
    tick(6);
    check("t2_out", bus.button_out, 32'h0);
    check("t2_held", {28'd0, bus.held}, 32'h0);

    // 3: overrun, then read-to-clear
    bus.blue_button = 1'b1;
    tick(8);
    check("t3_blue", bus.button_out, 32'h3);
    bus.yellow_button = 1'b1;
    tick(8);
    check("t3_overrun", bus.button_out, 32'hB);
    check("t3_held", {28'd0, bus.held}, 32'hA);
    bus.poll = 1'b1;
    tick(3);
    check("t3_stable_in_poll", bus.button_out, 32'hB);
    bus.poll = 1'b0;
    tick(1);
    check("t3_cleared", bus.button_out, 32'h0);
    bus.blue_button   = 1'b0;
    bus.yellow_button = 1'b0;
    tick(10);
    check("t3_released", {28'd0, bus.held}, 32'h0);

    // 4: simultaneous red and yellow
    bus.red_button    = 1'b1;
    bus.yellow_button = 1'b1;
    tick(8);
    check("t4_red_wins", bus.button_out, 32'h1);
    check("t4_held", {28'd0, bus.held}, 32'h9);
    bus.red_button    = 1'b0;
    bus.yellow_button = 1'b0;
    tick(10);
    bus.poll = 1'b1;
    tick(1);
    bus.poll = 1'b0;
    tick(1);
    check("t4_cleared", bus.button_out, 32'h0);

    // 5: green pulse on the poll falling edge while blue pending
    bus.blue_button = 1'b1;
    tick(8);
    check("t5_blue", bus.button_out, 32'h3);
    bus.green_button = 1'b1;
    bus.poll         = 1'b1;
    tick(6);
    bus.poll = 1'b0;
    tick(1);
    check("t5_press_wins", bus.button_out, 32'h5);
    check("t5_held", {28'd0, bus.held}, 32'h6);
    bus.blue_button  = 1'b0;
    bus.green_button = 1'b0;
    tick(10);
    bus.poll = 1'b1;
    tick(1);
    bus.poll = 1'b0;
    tick(1);
    check("t5_cleared", bus.button_out, 32'h0);

    // 6: reset mid-debounce with buttons still held
    bus.yellow_button = 1'b1;
    tick(8);
    check("t6_yellow", bus.button_out, 32'h7);
    bus.red_button = 1'b1;
    tick(4);
    reset = 1'b1;
    #1;
    check("t6_async_out", bus.button_out, 32'h0);
    check("t6_async_held", {28'd0, bus.held}, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(6);
    check("t6_before_7", bus.button_out, 32'h0);
    tick(1);
    check("t6_at_7", bus.button_out, 32'h1);
    check("t6_held", {28'd0, bus.held}, 32'h9);
    bus.red_button    = 1'b0;
    bus.yellow_button = 1'b0;
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
